// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one request in flight to instruction memory,
// a one-entry skid buffer for decode stalls, and redirect handling.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstd,
   input  logic        is_data_hazard,
   input  logic        is_redirect,
   input  logic [31:0] irreg_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] FD_inst,
   output logic [31:0] FD_pc,
   output logic        FD_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      STALL = 2'd2,
      DROP  = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] target;
   logic [31:0] buffer;
   logic [31:0] redirect_pc;
   logic [31:0] pc_seq;
   logic        unused_irreg_low;

   assign redirect_pc      = {irreg_pc[31:2], 2'b00};
   assign pc_seq           = pc + 32'd4;
   assign unused_irreg_low = &{1'b0, irreg_pc[1:0]};

   // Request and address come only from registers, so memory never sees a
   // combinational path from our inputs.
   assign imem_req  = (state == REQ) || (state == DROP);
   assign imem_addr = pc;

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rstd) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         target   <= 32'h0;
         buffer   <= 32'h0;
         FD_inst  <= NOP_INST;
         FD_pc    <= 32'h0;
         FD_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
               if (is_redirect) begin
                  pc       <= redirect_pc;
                  FD_inst  <= NOP_INST;
                  FD_valid <= 1'b0;
               end
            end

            REQ: begin
               if (is_redirect) begin
                  FD_inst  <= NOP_INST;
                  FD_valid <= 1'b0;
                  if (imem_ack) begin
                     pc <= redirect_pc;
                  end else begin
                     // The outstanding request must finish before re-targeting.
                     target <= redirect_pc;
                     state  <= DROP;
                  end
               end else if (imem_ack) begin
                  if (is_data_hazard) begin
                     buffer <= imem_rdata;
                     state  <= STALL;
                  end else begin
                     FD_inst  <= imem_rdata;
                     FD_pc    <= pc;
                     FD_valid <= 1'b1;
                     pc       <= pc_seq;
                  end
               end else if (!is_data_hazard) begin
                  FD_inst  <= NOP_INST;
                  FD_valid <= 1'b0;
               end
            end

            STALL: begin
               if (is_redirect) begin
                  FD_inst  <= NOP_INST;
                  FD_valid <= 1'b0;
                  pc       <= redirect_pc;
                  state    <= REQ;
               end else if (!is_data_hazard) begin
                  FD_inst  <= buffer;
                  FD_pc    <= pc;
                  FD_valid <= 1'b1;
                  pc       <= pc_seq;
                  state    <= REQ;
               end
            end

            DROP: begin
               FD_inst  <= NOP_INST;
               FD_valid <= 1'b0;
               if (imem_ack) begin
                  pc    <= is_redirect ? redirect_pc : target;
                  state <= REQ;
               end else if (is_redirect) begin
                  target <= redirect_pc;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (ADDI x0,x0,0), the bubble instruction.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstd  input  1  reset, synchronous and active-high.
REQ-005 is_data_hazard  input  1  decode-stage stall; FD register must hold.
REQ-006 is_redirect  input  1  branch/jump resolved to a non-sequential target this cycle.
REQ-007 irreg_pc  input  32  redirect target, sampled only when is_redirect=1.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  instruction-memory word address, bits[1:0] always 0.
REQ-010 imem_ack  input  1  memory response valid; data on imem_rdata same cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 FD_inst  output  32  registered instruction to decode.
REQ-013 FD_pc  output  32  registered PC of FD_inst.
REQ-014 FD_valid  output  1  FD_inst is a real instruction (0 = bubble).

Function
REQ-015 States: IDLE, REQ, STALL, DROP; 2-bit state register.
REQ-016 imem_req = 1 exactly in REQ and DROP; imem_addr = pc register in all states; imem_req and imem_addr are state/register-derived only (no input-to-output path).
REQ-017 Once imem_req rises, imem_addr stays constant until the cycle imem_ack=1; ack is accepted in the same cycle it is asserted; imem_ack outside REQ/DROP is ignored.
REQ-018 IDLE -> REQ unconditionally on the cycle after reset deasserts.
REQ-019 REQ, ack, no hazard, no redirect: FD_inst<=imem_rdata, FD_pc<=pc, FD_valid<=1, pc<=pc+4; stay REQ (one instruction per cycle at zero-wait memory).
REQ-020 REQ, ack, hazard, no redirect: FD holds; imem_rdata captured in skid buffer; pc unchanged; -> STALL.
REQ-021 REQ, no ack, no hazard, no redirect: FD_inst<=NOP_INST, FD_valid<=0, FD_pc holds; stay REQ.
REQ-022 REQ, no ack, hazard: FD holds; stay REQ.
REQ-023 STALL: imem_req=0; while hazard=1 FD and buffer hold; when hazard=0: FD_inst<=buffer, FD_pc<=pc, FD_valid<=1, pc<=pc+4, -> REQ.
REQ-024 Redirect has priority over hazard and ack in every state; in its cycle FD_inst<=NOP_INST, FD_valid<=0, FD_pc holds.
REQ-025 Redirect in REQ with ack same cycle, or in STALL: data/buffer discarded, pc<={irreg_pc[31:2],2'b00}, -> REQ.
REQ-026 Redirect in REQ without ack: target<={irreg_pc[31:2],2'b00}, -> DROP (outstanding request must complete).
REQ-027 DROP: request held at old pc; FD_inst=NOP_INST, FD_valid=0; a further redirect overwrites target; on ack data discarded, pc<=target (or new irreg_pc if redirect same cycle), -> REQ.
REQ-028 Redirect in IDLE: pc<=aligned irreg_pc, -> REQ.
REQ-029 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-030 Skid buffer depth exactly 1; no second request issued while STALL.

Reset
REQ-031 rstd=1 at a rising edge, in any state and mid-transaction: state<=IDLE, pc<=RESET_PC, target<=0, buffer<=0, FD_inst<=NOP_INST, FD_pc<=0, FD_valid<=0; imem_req=0 the following cycle.
REQ-032 An imem_ack arriving while in IDLE after reset is ignored; reset overrides all other inputs.

Verification
REQ-033 Reset release, imem_ack tied 1 -> imem_addr 0,4,8 on successive cycles; FD_pc 0,4 with FD_valid=1 one cycle later each.
REQ-034 Ack with hazard=1 for 3 cycles at pc=8 -> FD holds pc=4 instruction, imem_req=0; on hazard=0 FD_pc=8, FD_valid=1, next imem_addr=12.
REQ-035 Ack delayed 2 cycles at pc=16 -> imem_addr stable at 16, FD_valid=0, FD_inst=32'h0000_0013 during wait.
REQ-036 Redirect to 32'h103 while request at 20 pending, ack 2 cycles later -> DROP, address 20 held, its data discarded, next imem_addr=32'h100.
REQ-037 Redirect coincident with hazard=1 and ack -> FD_valid=0, FD_inst=NOP_INST, next imem_addr=target; pc=32'hFFFF_FFFC with ack -> next imem_addr=0.
REQ-038 rstd=1 during DROP -> next cycle IDLE, imem_req=0, FD_valid=0, then imem_addr=RESET_PC.
